// File: rtl/noc_flit_sink_axis.sv
`timescale 1ns/1ps
// Credit-based NoC flit sink: buffers incoming flits, returns one credit per
// consumed flit and packs SERIALIZATION_FACTOR flits into each AXI4-Stream beat.
module noc_flit_sink_axis #(
    parameter int TDATA_WIDTH          = 32,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
    parameter int BUFFER_DEPTH         = 4
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic                   axis_tlast,
    output logic [TID_WIDTH-1:0]   axis_tid,
    output logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic                   overflow_err
);

    localparam int SF          = SERIALIZATION_FACTOR;
    localparam int PTR_WIDTH   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_WIDTH   = $clog2(BUFFER_DEPTH + 1);
    localparam int K_WIDTH     = (SF > 1) ? $clog2(SF) : 1;
    localparam int ENTRY_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [ENTRY_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [CNT_WIDTH-1:0]   count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic                   drop;

    logic [FLIT_WIDTH-1:0]  head_data;
    logic [DEST_WIDTH-1:0]  head_dest;
    logic                   head_tail;

    logic [0:0]             state;
    logic [K_WIDTH-1:0]     k;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_WIDTH'(BUFFER_DEPTH));
    assign {head_data, head_dest, head_tail} = mem[rd_ptr];

    // A handshake in HOLD frees the output register, so the next flit can be
    // popped in the same cycle as flit 0 of the following beat.
    assign pop  = !fifo_empty && ((state == ST_COLLECT) || axis_tready);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push = send_in && (!fifo_full || pop);
    assign drop = send_in && fifo_full && !pop;

    assign axis_tvalid = (state == ST_HOLD);

    // NOTE: the storage array has no reset; the pointers and count alone
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers sample the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_WIDTH'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            credit_out <= pop;
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Beat assembler: flit k lands in slice k (LSB first); a tail flit or the
    // last slot closes the beat and moves to HOLD.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state      <= ST_COLLECT;
            k          <= '0;
            axis_tdata <= '0;
            axis_tlast <= 1'b0;
            axis_tid   <= '0;
            axis_tdest <= '0;
        end else if (pop) begin
            if ((state == ST_HOLD) || (k == '0)) begin
                axis_tdata <= TDATA_WIDTH'(head_data);
                axis_tid   <= head_dest[DEST_WIDTH-1 -: TID_WIDTH];
                axis_tdest <= head_dest[TDEST_WIDTH-1:0];
                axis_tlast <= head_tail;
                if ((SF == 1) || head_tail) begin
                    state <= ST_HOLD;
                    k     <= '0;
                end else begin
                    state <= ST_COLLECT;
                    k     <= K_WIDTH'(1);
                end
            end else begin
                axis_tdata[int'(k) * FLIT_WIDTH +: FLIT_WIDTH] <= head_data;
                axis_tlast <= head_tail;
                if (head_tail || (k == K_WIDTH'(SF - 1))) begin
                    state <= ST_HOLD;
                    k     <= '0;
                end else begin
                    k <= k + K_WIDTH'(1);
                end
            end
        end else if ((state == ST_HOLD) && axis_tready) begin
            state <= ST_COLLECT;
        end
    end

endmodule

// File: tb/tb_noc_flit_sink_axis.sv
`timescale 1ns/1ps
// Directed bench for noc_flit_sink_axis (SF=2, 16-bit flits, depth-4 FIFO):
// beats are captured on each handshake and compared against hand-computed tables.
module tb_noc_flit_sink_axis;

    localparam int TDATA_WIDTH  = 32;
    localparam int TID_WIDTH    = 2;
    localparam int TDEST_WIDTH  = 4;
    localparam int SF           = 2;
    localparam int FLIT_WIDTH   = 16;
    localparam int DEST_WIDTH   = 6;
    localparam int BUFFER_DEPTH = 4;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic                   last;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
    } beat_t;

    logic                   clk_noc = 1'b0;
    logic                   rst_noc;
    logic [FLIT_WIDTH-1:0]  data_in;
    logic [DEST_WIDTH-1:0]  dest_in;
    logic                   is_tail_in;
    logic                   send_in;
    logic                   credit_out;
    logic                   axis_tvalid;
    logic                   axis_tready;
    logic [TDATA_WIDTH-1:0] axis_tdata;
    logic                   axis_tlast;
    logic [TID_WIDTH-1:0]   axis_tid;
    logic [TDEST_WIDTH-1:0] axis_tdest;
    logic                   overflow_err;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    credit_total = 0;
    int    sent_total   = 0;
    beat_t obs_q[$];

    noc_flit_sink_axis #(
        .TDATA_WIDTH(TDATA_WIDTH), .TID_WIDTH(TID_WIDTH), .TDEST_WIDTH(TDEST_WIDTH),
        .SERIALIZATION_FACTOR(SF), .FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH),
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) dut (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
        .axis_tlast(axis_tlast), .axis_tid(axis_tid), .axis_tdest(axis_tdest),
        .overflow_err(overflow_err)
    );

    always #5 clk_noc = ~clk_noc;

    // Mid-cycle monitor: records accepted beats and counts credit pulses.
    always @(negedge clk_noc) begin
        if (!rst_noc) begin
            if (axis_tvalid && axis_tready) begin
                obs_q.push_back(beat_t'{axis_tdata, axis_tlast, axis_tid, axis_tdest});
            end
            if (credit_out) begin
                credit_total++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic apply_reset();
        rst_noc     = 1'b1;
        send_in     = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        axis_tready = 1'b0;
        repeat (2) cycle();
        rst_noc    = 1'b0;
        sent_total = credit_total;
        cycle();
    endtask

    task automatic send_flit(input logic [15:0] d, input logic [5:0] ds, input logic t);
        data_in    = d;
        dest_in    = ds;
        is_tail_in = t;
        send_in    = 1'b1;
        sent_total++;
        cycle();
        send_in = 1'b0;
    endtask

    // Upstream model: sends only while in-flight flits are below the credit limit.
    task automatic send_credited(input int n, input logic [15:0] base, input logic [5:0] ds,
                                 input int tail_every, output int stalls);
        int i;
        i      = 0;
        stalls = 0;
        while (i < n) begin
            if (sent_total - credit_total < BUFFER_DEPTH) begin
                data_in    = base + 16'(i);
                dest_in    = ds;
                is_tail_in = ((i % tail_every) == tail_every - 1) || (i == n - 1);
                send_in    = 1'b1;
                sent_total++;
                i++;
            end else begin
                send_in = 1'b0;
                stalls++;
            end
            cycle();
        end
        send_in = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        for (int c = 0; c < budget && obs_q.size() < target; c++) cycle();
        n_checks++;
        if (obs_q.size() < target) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name, obs_q.size(), target);
        end
    endtask

    task automatic check_beats(input int base, input beat_t exp[], input string name);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= obs_q.size() || obs_q[base + i] !== exp[i]) begin
                n_fail++;
                if (base + i >= obs_q.size())
                    $display("FAIL %s beat %0d: missing, required data=%h", name, i, exp[i].data);
                else
                    $display("FAIL %s beat %0d: got data=%h last=%b tid=%h tdest=%h, required data=%h last=%b tid=%h tdest=%h",
                             name, i, obs_q[base + i].data, obs_q[base + i].last, obs_q[base + i].tid,
                             obs_q[base + i].tdest, exp[i].data, exp[i].last, exp[i].tid, exp[i].tdest);
            end
        end
    endtask

    task automatic test_reset();
        rst_noc     = 1'b1;
        send_in     = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        axis_tready = 1'b0;
        #3;
        n_checks++;
        if ({axis_tvalid, credit_out, overflow_err, axis_tlast} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got tvalid=%b credit=%b ovf=%b tlast=%b, required all 0",
                     axis_tvalid, credit_out, overflow_err, axis_tlast);
        end
        n_checks++;
        if ({axis_tdata, axis_tid, axis_tdest} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got tdata=%h tid=%h tdest=%h, required 0", axis_tdata, axis_tid, axis_tdest);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        int    base;
        int    cred0;
        beat_t exp[];
        base        = obs_q.size();
        cred0       = credit_total;
        axis_tready = 1'b1;
        send_flit(16'h1111, 6'h25, 1'b0);
        send_flit(16'h2222, 6'h25, 1'b1);
        wait_beats(base + 1, 20, "basic");
        repeat (5) cycle();
        exp = new[1];
        exp[0] = beat_t'{32'h2222_1111, 1'b1, 2'd2, 4'd5};
        check_beats(base, exp, "basic");
        n_checks++;
        if (credit_total - cred0 !== 2) begin
            n_fail++;
            $display("FAIL basic_credits: got %0d, required 2", credit_total - cred0);
        end
    endtask

    task automatic test_latency();
        int base;
        base        = obs_q.size();
        axis_tready = 1'b0;
        send_flit(16'h5555, 6'h3A, 1'b1);
        n_checks++;
        if (axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got tvalid=%b one cycle after send, required 0", axis_tvalid);
        end
        cycle();
        n_checks++;
        if (axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_valid: got tvalid=%b two cycles after send, required 1", axis_tvalid);
        end
        n_checks++;
        if ({axis_tdata, axis_tlast, axis_tid, axis_tdest} !== {32'h0000_5555, 1'b1, 2'd3, 4'hA}) begin
            n_fail++;
            $display("FAIL latency_beat: got data=%h last=%b tid=%h tdest=%h, required 00005555 1 3 a",
                     axis_tdata, axis_tlast, axis_tid, axis_tdest);
        end
        axis_tready = 1'b1;
        wait_beats(base + 1, 10, "latency_drain");
    endtask

    task automatic test_three_flit();
        int    base;
        int    cred0;
        beat_t exp[];
        base        = obs_q.size();
        cred0       = credit_total;
        axis_tready = 1'b1;
        send_flit(16'hAAAA, 6'h13, 1'b0);
        send_flit(16'hBBBB, 6'h13, 1'b0);
        send_flit(16'hCCCC, 6'h13, 1'b1);
        wait_beats(base + 2, 20, "three_flit");
        repeat (5) cycle();
        exp = new[2];
        exp[0] = beat_t'{32'hBBBB_AAAA, 1'b0, 2'd1, 4'd3};
        exp[1] = beat_t'{32'h0000_CCCC, 1'b1, 2'd1, 4'd3};
        check_beats(base, exp, "three_flit");
        n_checks++;
        if (credit_total - cred0 !== 3) begin
            n_fail++;
            $display("FAIL three_flit_credits: got %0d, required 3", credit_total - cred0);
        end
    endtask

    task automatic test_back_to_back();
        int    base;
        int    cred0;
        int    stalls;
        beat_t exp[];
        base        = obs_q.size();
        cred0       = credit_total;
        axis_tready = 1'b1;
        send_credited(10, 16'h1000, 6'h2C, 5, stalls);
        wait_beats(base + 6, 40, "back_to_back");
        repeat (5) cycle();
        exp = new[6];
        exp[0] = beat_t'{32'h1001_1000, 1'b0, 2'd2, 4'hC};
        exp[1] = beat_t'{32'h1003_1002, 1'b0, 2'd2, 4'hC};
        exp[2] = beat_t'{32'h0000_1004, 1'b1, 2'd2, 4'hC};
        exp[3] = beat_t'{32'h1006_1005, 1'b0, 2'd2, 4'hC};
        exp[4] = beat_t'{32'h1008_1007, 1'b0, 2'd2, 4'hC};
        exp[5] = beat_t'{32'h0000_1009, 1'b1, 2'd2, 4'hC};
        check_beats(base, exp, "back_to_back");
        n_checks++;
        if (stalls !== 0) begin
            n_fail++;
            $display("FAIL back_to_back_stalls: got %0d credit stalls, required 0", stalls);
        end
        n_checks++;
        if (credit_total - cred0 !== 10) begin
            n_fail++;
            $display("FAIL back_to_back_credits: got %0d, required 10", credit_total - cred0);
        end
    endtask

    task automatic test_random_ready();
        int    base;
        int    stalls;
        beat_t exp[];
        base = obs_q.size();
        fork
            send_credited(8, 16'h2000, 6'h07, 4, stalls);
            begin
                logic  held;
                beat_t prev;
                beat_t cur;
                held = 1'b0;
                prev = '0;
                for (int c = 0; c < 120; c++) begin
                    @(posedge clk_noc);
                    #1;
                    axis_tready = 1'($urandom_range(0, 1));
                    @(negedge clk_noc);
                    cur = beat_t'{axis_tdata, axis_tlast, axis_tid, axis_tdest};
                    if (held) begin
                        n_checks++;
                        if (axis_tvalid !== 1'b1 || cur !== prev) begin
                            n_fail++;
                            $display("FAIL random_ready_hold: got tvalid=%b data=%h last=%b, required 1 data=%h last=%b",
                                     axis_tvalid, cur.data, cur.last, prev.data, prev.last);
                        end
                    end
                    held = axis_tvalid && !axis_tready;
                    prev = cur;
                end
            end
        join
        @(posedge clk_noc);
        #1;
        axis_tready = 1'b1;
        wait_beats(base + 4, 40, "random_ready");
        exp = new[4];
        exp[0] = beat_t'{32'h2001_2000, 1'b0, 2'd0, 4'd7};
        exp[1] = beat_t'{32'h2003_2002, 1'b1, 2'd0, 4'd7};
        exp[2] = beat_t'{32'h2005_2004, 1'b0, 2'd0, 4'd7};
        exp[3] = beat_t'{32'h2007_2006, 1'b1, 2'd0, 4'd7};
        check_beats(base, exp, "random_ready");
    endtask

    task automatic test_overflow();
        int    base;
        int    cred0;
        beat_t exp[];
        base        = obs_q.size();
        cred0       = credit_total;
        axis_tready = 1'b0;
        send_flit(16'h0F00, 6'h00, 1'b1);
        send_flit(16'h0F01, 6'h00, 1'b0);
        send_flit(16'h0F02, 6'h00, 1'b0);
        send_flit(16'h0F03, 6'h00, 1'b0);
        send_flit(16'h0F04, 6'h00, 1'b1);
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_early: got %b after 5 flits, required 0", overflow_err);
        end
        send_flit(16'h0BAD, 6'h00, 1'b0);
        n_checks++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b after 6th flit, required 1", overflow_err);
        end
        axis_tready = 1'b1;
        wait_beats(base + 3, 30, "overflow_drain");
        repeat (10) cycle();
        exp = new[3];
        exp[0] = beat_t'{32'h0000_0F00, 1'b1, 2'd0, 4'd0};
        exp[1] = beat_t'{32'h0F02_0F01, 1'b0, 2'd0, 4'd0};
        exp[2] = beat_t'{32'h0F04_0F03, 1'b1, 2'd0, 4'd0};
        check_beats(base, exp, "overflow");
        n_checks++;
        if (obs_q.size() !== base + 3) begin
            n_fail++;
            $display("FAIL overflow_dropped: got %0d beats, required %0d", obs_q.size() - base, 3);
        end
        n_checks++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b, required 1", overflow_err);
        end
        n_checks++;
        if (credit_total - cred0 !== 5) begin
            n_fail++;
            $display("FAIL overflow_credits: got %0d, required 5", credit_total - cred0);
        end
    endtask

    task automatic test_reset_mid();
        int    base;
        beat_t exp[];
        apply_reset();
        axis_tready = 1'b0;
        send_flit(16'h7777, 6'h25, 1'b1);
        send_flit(16'h9999, 6'h25, 1'b0);
        cycle();
        #2;
        rst_noc = 1'b1;
        #1;
        n_checks++;
        if ({axis_tvalid, credit_out, overflow_err, axis_tlast} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: got tvalid=%b credit=%b ovf=%b tlast=%b, required all 0",
                     axis_tvalid, credit_out, overflow_err, axis_tlast);
        end
        n_checks++;
        if ({axis_tdata, axis_tid, axis_tdest} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_data: got tdata=%h tid=%h tdest=%h, required 0", axis_tdata, axis_tid, axis_tdest);
        end
        cycle();
        cycle();
        rst_noc    = 1'b0;
        sent_total = credit_total;
        cycle();
        base        = obs_q.size();
        axis_tready = 1'b1;
        send_flit(16'h3333, 6'h25, 1'b0);
        send_flit(16'h4444, 6'h25, 1'b1);
        wait_beats(base + 1, 20, "reset_mid");
        repeat (10) cycle();
        exp = new[1];
        exp[0] = beat_t'{32'h4444_3333, 1'b1, 2'd2, 4'd5};
        check_beats(base, exp, "reset_mid");
        n_checks++;
        if (obs_q.size() !== base + 1) begin
            n_fail++;
            $display("FAIL reset_mid_residue: got %0d beats, required 1", obs_q.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_three_flit();
        test_back_to_back();
        test_random_ready();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
